// File: rtl/usb_upload_pkg.sv
// Shared types and constants for the USB upload packetizer slice.
package usb_upload_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_e;

  localparam int USB_FS_BULK_MAX = 64;
  localparam int USB_HS_BULK_MAX = 512;

endpackage

// File: rtl/usb_upload_packetizer_if.sv
// Upload byte stream in, bulk-IN endpoint stream out; master is the packetizer side.
interface usb_upload_packetizer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       flush;
  logic [7:0] ep_data;
  logic       ep_valid;
  logic       ep_last;
  logic       ep_ready;

  modport master (
    input  in_data, in_valid, flush, ep_ready,
    output ep_data, ep_valid, ep_last
  );

  modport slave (
    output in_data, in_valid, flush, ep_ready,
    input  ep_data, ep_valid, ep_last
  );
endinterface

// File: rtl/upload_byte_ram.sv
// Simple dual-port byte RAM, synchronous read with 1-cycle latency; output holds when re is low.
module upload_byte_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [7:0]               wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [7:0]               rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/usb_upload_packetizer.sv
// Buffers the core's upload byte stream and emits bounded bulk-IN packets
// on size, write-idle timeout or explicit flush.
module usb_upload_packetizer
  import usb_upload_pkg::*;
#(
  parameter int DEPTH         = 1024,
  parameter int PKT_SIZE      = USB_HS_BULK_MAX,
  parameter int FLUSH_TIMEOUT = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  usb_upload_packetizer_if.master bus,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [15:0]            drop_count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

  state_e          state, state_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, remaining;
  logic [TW-1:0]   timer;
  logic            flush_pend;
  logic [7:0]      rd_data_p1;

  logic wr_en, drop, hs, rd_en, go_load;

  assign wr_en   = bus.in_valid && (count < CW'(DEPTH));
  assign drop    = bus.in_valid && !wr_en;
  assign hs      = (state == SEND) && bus.ep_ready;
  // The RAM output register is the prefetch stage: it only advances on LOAD or a
  // non-final handshake, so it holds the presented byte through stalls.
  assign rd_en   = (state == LOAD) || (hs && (remaining > CW'(1)));
  assign go_load = (state == IDLE) && (count != '0) &&
                   ((count >= CW'(PKT_SIZE)) || (timer == TW'(FLUSH_TIMEOUT)) || flush_pend);

  upload_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.in_data),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (rd_data_p1)
  );

  always_comb begin
    state_nxt    = state;
    bus.ep_valid = 1'b0;
    bus.ep_last  = 1'b0;
    bus.ep_data  = 8'h00;
    case (state)
      IDLE: if (go_load) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: begin
        bus.ep_valid = 1'b1;
        bus.ep_last  = (remaining == CW'(1));
        bus.ep_data  = rd_data_p1;
        if (hs && (remaining == CW'(1))) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      remaining  <= '0;
      timer      <= '0;
      flush_pend <= 1'b0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      // Occupancy drops on handshake, not prefetch, so unsent bytes are never overwritten.
      case ({wr_en, hs})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (go_load)
        remaining <= (count >= CW'(PKT_SIZE)) ? CW'(PKT_SIZE) : count;
      else if (hs)
        remaining <= remaining - CW'(1);
      if (wr_en || (count == '0) || go_load)
        timer <= '0;
      else if ((state == IDLE) && (timer != TW'(FLUSH_TIMEOUT)))
        timer <= timer + TW'(1);
      if (go_load || (count == '0))
        flush_pend <= 1'b0;
      else if (bus.flush)
        flush_pend <= 1'b1;
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      if (drop) overflow <= 1'b1;
    end
  end

  assign fill_level = count;

endmodule

// File: tb/tb_usb_upload_packetizer.sv
// Directed bench for usb_upload_packetizer: size, timeout, flush, overflow, stall and reset scenarios.
module tb_usb_upload_packetizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] fill_level;
  logic [15:0] drop_count;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] rx_data [$];
  bit         rx_last [$];
  int         rx_cyc  [$];

  usb_upload_packetizer_if bus ();

  usb_upload_packetizer #(
    .DEPTH(1024), .PKT_SIZE(512), .FLUSH_TIMEOUT(1000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fill_level (fill_level),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ep_valid && bus.ep_ready) begin
      rx_data.push_back(bus.ep_data);
      rx_last.push_back(bus.ep_last);
      rx_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_last.delete();
    rx_cyc.delete();
  endtask

  task automatic write_burst(input int n, input int mul, input int add);
    for (int i = 0; i < n; i++) begin
      bus.in_data  = 8'(i * mul + add);
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_data.size() < n && k < budget) begin
      step();
      k++;
    end
    repeat (5) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.flush = 1'b0; bus.ep_ready = 1'b0;
    repeat (3) step();
    checks++; if (bus.ep_valid !== 1'b0) begin failures++; $display("FAIL reset_ep_valid got=%0b exp=0", bus.ep_valid); end
    checks++; if (bus.ep_last !== 1'b0) begin failures++; $display("FAIL reset_ep_last got=%0b exp=0", bus.ep_last); end
    checks++; if (bus.ep_data !== 8'h00) begin failures++; $display("FAIL reset_ep_data got=%h exp=00", bus.ep_data); end
    checks++; if (fill_level !== 11'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_packet();
    int bad_data = 0, bad_last = 0, bubbles = 0;
    clear_rx();
    bus.ep_ready = 1'b1;
    write_burst(512, 1, 0);
    wait_rx(512, 2000);
    checks++; if (rx_data.size() != 512) begin failures++; $display("FAIL full_pkt_len got=%0d exp=512", rx_data.size()); end
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] !== 8'(i)) bad_data++;
      if (rx_last[i] !== (i == 511)) bad_last++;
      if (rx_cyc[i] != rx_cyc[0] + i) bubbles++;
    end
    checks++; if (bad_data != 0) begin failures++; $display("FAIL full_pkt_data bad_bytes=%0d exp=0", bad_data); end
    checks++; if (bad_last != 0) begin failures++; $display("FAIL full_pkt_last bad_flags=%0d exp=0", bad_last); end
    checks++; if (bubbles != 0) begin failures++; $display("FAIL full_pkt_bubbles got=%0d exp=0", bubbles); end
    checks++; if (fill_level !== 11'd0) begin failures++; $display("FAIL full_pkt_fill got=%0d exp=0", fill_level); end
  endtask

  task automatic test_timeout();
    int n = 0, bad = 0;
    clear_rx();
    bus.ep_ready = 1'b1;
    write_burst(5, 1, 'h40);
    checks++; if (fill_level !== 11'd5) begin failures++; $display("FAIL timeout_fill got=%0d exp=5", fill_level); end
    while (!bus.ep_valid && n < 1100) begin
      step();
      n++;
    end
    checks++; if (n != 1002) begin failures++; $display("FAIL timeout_latency got=%0d exp=1002", n); end
    wait_rx(5, 50);
    checks++; if (rx_data.size() != 5) begin failures++; $display("FAIL timeout_len got=%0d exp=5", rx_data.size()); end
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] !== 8'(8'h40 + i) || rx_last[i] !== (i == 4)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL timeout_bytes bad=%0d exp=0", bad); end
  endtask

  task automatic test_flush();
    int n = 0, bad = 0, seen = 0;
    clear_rx();
    bus.ep_ready = 1'b1;
    write_burst(3, 1, 'h90);
    pulse_flush();
    while (!bus.ep_valid && n < 50) begin
      step();
      n++;
    end
    checks++; if (n != 2) begin failures++; $display("FAIL flush_latency got=%0d exp=2", n); end
    wait_rx(3, 20);
    checks++; if (rx_data.size() != 3) begin failures++; $display("FAIL flush_len got=%0d exp=3", rx_data.size()); end
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] !== 8'(8'h90 + i) || rx_last[i] !== (i == 2)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL flush_bytes bad=%0d exp=0", bad); end
    pulse_flush();
    for (int i = 0; i < 20; i++) begin
      if (bus.ep_valid) seen++;
      step();
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL empty_flush valid_cycles=%0d exp=0", seen); end
  endtask

  task automatic test_overflow();
    int bad = 0;
    clear_rx();
    bus.ep_ready = 1'b0;
    write_burst(1024, 1, 0);
    checks++; if (fill_level !== 11'd1024) begin failures++; $display("FAIL ovf_fill got=%0d exp=1024", fill_level); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL ovf_drop_pre got=%0d exp=0", drop_count); end
    write_burst(6, 1, 'h55);
    checks++; if (drop_count !== 16'd6) begin failures++; $display("FAIL ovf_drop got=%0d exp=6", drop_count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    checks++; if (fill_level !== 11'd1024) begin failures++; $display("FAIL ovf_fill_hold got=%0d exp=1024", fill_level); end
    checks++; if (bus.ep_valid !== 1'b1 || bus.ep_data !== 8'h00) begin failures++; $display("FAIL ovf_stalled got_v=%0b got_d=%h exp_v=1 exp_d=00", bus.ep_valid, bus.ep_data); end
    bus.ep_ready = 1'b1;
    wait_rx(1024, 3000);
    checks++; if (rx_data.size() != 1024) begin failures++; $display("FAIL ovf_drain_len got=%0d exp=1024", rx_data.size()); end
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] !== 8'(i) || rx_last[i] !== (i == 511 || i == 1023)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL ovf_drain_bytes bad=%0d exp=0", bad); end
    checks++; if (fill_level !== 11'd0) begin failures++; $display("FAIL ovf_drain_fill got=%0d exp=0", fill_level); end
  endtask

  task automatic test_back_to_back_stall();
    int stall_err = 0, bad = 0, k = 0;
    clear_rx();
    bus.ep_ready = 1'b0;
    fork
      write_burst(700, 7, 3);
      begin
        bit         stalled = 1'b0;
        logic [7:0] prev_d = 8'h00;
        logic       prev_l = 1'b0;
        while (rx_data.size() < 700 && k < 6000) begin
          @(negedge clk);
          if (stalled && (!bus.ep_valid || bus.ep_data !== prev_d || bus.ep_last !== prev_l)) stall_err++;
          stalled = bus.ep_valid && !bus.ep_ready;
          prev_d  = bus.ep_data;
          prev_l  = bus.ep_last;
          @(posedge clk);
          #1;
          bus.ep_ready = 1'($urandom_range(0, 1));
          k++;
        end
        bus.ep_ready = 1'b1;
      end
    join
    wait_rx(700, 10);
    checks++; if (rx_data.size() != 700) begin failures++; $display("FAIL stall_len got=%0d exp=700", rx_data.size()); end
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] !== 8'(i * 7 + 3) || rx_last[i] !== (i == 511 || i == 699)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_bytes bad=%0d exp=0", bad); end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL stall_stability errs=%0d exp=0", stall_err); end
  endtask

  task automatic test_reset_mid_packet();
    int n = 0, bad = 0;
    bus.ep_ready = 1'b0;
    write_burst(20, 1, 'h10);
    pulse_flush();
    while (!bus.ep_valid && n < 20) begin
      step();
      n++;
    end
    checks++; if (bus.ep_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%0b exp=1", bus.ep_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ep_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", bus.ep_valid); end
    checks++; if (fill_level !== 11'd0) begin failures++; $display("FAIL midrst_fill got=%0d exp=0", fill_level); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL midrst_drop got=%0d exp=0", drop_count); end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    clear_rx();
    bus.ep_ready = 1'b1;
    write_burst(10, 1, 'hA0);
    pulse_flush();
    wait_rx(10, 50);
    repeat (20) step();
    checks++; if (rx_data.size() != 10) begin failures++; $display("FAIL midrst_pkt_len got=%0d exp=10", rx_data.size()); end
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] !== 8'(8'hA0 + i) || rx_last[i] !== (i == 9)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL midrst_pkt_bytes bad=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_timeout();
    test_flush();
    test_overflow();
    test_back_to_back_stall();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
